ts_queue_sc: RTL and testbench

TS_QUEUE_SC -- requirements
Module: ts_queue_sc

---
 rtl/ts_queue_pkg.sv | 12 +
 rtl/ts_queue_ram.sv | 26 ++
 rtl/ts_queue_sc.sv | 129 ++++++++++++
 tb/tb_ts_queue_sc.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ts_queue_pkg.sv
// Shared defaults and entry layout for the timestamp queue.
package ts_queue_pkg;

   localparam int unsigned TS_W_DEF = 80;
   localparam int unsigned ID_W_DEF = 16;

   typedef struct packed {
      logic [ID_W_DEF-1:0] id;
      logic [TS_W_DEF-1:0] ts;
   } ts_entry;

endpackage

// File: rtl/ts_queue_ram.sv
// Queue storage: synchronous write, asynchronous read, no reset.
module ts_queue_ram
   import ts_queue_pkg::*;
#(
   parameter int unsigned W     = ID_W_DEF + TS_W_DEF,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ts_queue_sc.sv
// Show-ahead single-clock timestamp queue with drop-new or overwrite-oldest on full.
// Optional statistics outputs (drop_cnt, hwm) are built when TS_QUEUE_STATS_EN is defined.
module ts_queue_sc
   import ts_queue_pkg::*;
#(
   parameter int unsigned TS_W      = TS_W_DEF,
   parameter int unsigned ID_W      = ID_W_DEF,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned OVERWRITE = 0
) (
   input  logic                   clk,
   input  logic                   aclr,
   input  logic                   wr_valid,
   input  logic [ID_W-1:0]        wr_id,
   input  logic [TS_W-1:0]        wr_ts,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [ID_W-1:0]        rd_id,
   output logic [TS_W-1:0]        rd_ts,
   output logic [$clog2(DEPTH):0] usedw,
   output logic                   full,
   output logic                   drop_pulse
`ifdef TS_QUEUE_STATS_EN
   ,
   output logic [15:0]            drop_cnt,
   output logic [$clog2(DEPTH):0] hwm
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned W  = ID_W + TS_W;

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] usedw_q, usedw_d;
   logic          pop;
   logic          wr_en;
   logic          drop;
   logic [W-1:0]  rd_data;

   assign rd_valid   = (usedw_q != '0);
   assign full       = (usedw_q == CW'(DEPTH));
   assign usedw      = usedw_q;
   assign drop_pulse = drop;
   assign rd_id      = rd_data[W-1:TS_W];
   assign rd_ts      = rd_data[TS_W-1:0];

   always_comb begin
      pop     = rd_valid & rd_ready;
      wr_en   = 1'b0;
      drop    = 1'b0;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      usedw_d = usedw_q;

      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end

      if (wr_valid) begin
         if (!full || pop) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + 1'b1;
         end else if (OVERWRITE != 0) begin
            // Full with no pop: evict the oldest entry to make room.
            wr_en  = 1'b1;
            wptr_d = wptr_q + 1'b1;
            rptr_d = rptr_q + 1'b1;
            drop   = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end

      if (wr_en && !pop && !full) begin
         usedw_d = usedw_q + 1'b1;
      end else if (pop && !wr_en) begin
         usedw_d = usedw_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         usedw_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         usedw_q <= usedw_d;
      end
   end

   ts_queue_ram #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wptr_q),
      .wr_data ({wr_id, wr_ts}),
      .rd_addr (rptr_q),
      .rd_data (rd_data)
   );

`ifdef TS_QUEUE_STATS_EN
   logic [15:0]   drop_cnt_q;
   logic [CW-1:0] hwm_q;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         drop_cnt_q <= '0;
         hwm_q      <= '0;
      end else begin
         if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end
         if (usedw_d > hwm_q) begin
            hwm_q <= usedw_d;
         end
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign hwm      = hwm_q;
`endif

endmodule

// File: tb/tb_ts_queue_sc.sv
// Directed bench for ts_queue_sc: two DEPTH=4 instances (drop-new and overwrite) share stimulus.
// Statistics checks run only when TS_QUEUE_STATS_EN is defined.
module tb_ts_queue_sc;

   localparam int unsigned TS_W  = 80;
   localparam int unsigned ID_W  = 16;
   localparam int unsigned DEPTH = 4;

   logic            clk;
   logic            aclr;
   logic            wr_valid;
   logic [ID_W-1:0] wr_id;
   logic [TS_W-1:0] wr_ts;
   logic            rd_ready;

   logic            rv0, rv1;
   logic [ID_W-1:0] rid0, rid1;
   logic [TS_W-1:0] rts0, rts1;
   logic [2:0]      u0, u1;
   logic            f0, f1;
   logic            dp0, dp1;
`ifdef TS_QUEUE_STATS_EN
   logic [15:0]     dc0, dc1;
   logic [2:0]      hw0, hw1;
`endif

   int checks = 0;
   int errors = 0;

   ts_queue_sc #(.TS_W(TS_W), .ID_W(ID_W), .DEPTH(DEPTH), .OVERWRITE(0)) u_dut0 (
      .clk        (clk),
      .aclr       (aclr),
      .wr_valid   (wr_valid),
      .wr_id      (wr_id),
      .wr_ts      (wr_ts),
      .rd_ready   (rd_ready),
      .rd_valid   (rv0),
      .rd_id      (rid0),
      .rd_ts      (rts0),
      .usedw      (u0),
      .full       (f0),
      .drop_pulse (dp0)
`ifdef TS_QUEUE_STATS_EN
      ,
      .drop_cnt   (dc0),
      .hwm        (hw0)
`endif
   );

   ts_queue_sc #(.TS_W(TS_W), .ID_W(ID_W), .DEPTH(DEPTH), .OVERWRITE(1)) u_dut1 (
      .clk        (clk),
      .aclr       (aclr),
      .wr_valid   (wr_valid),
      .wr_id      (wr_id),
      .wr_ts      (wr_ts),
      .rd_ready   (rd_ready),
      .rd_valid   (rv1),
      .rd_id      (rid1),
      .rd_ts      (rts1),
      .usedw      (u1),
      .full       (f1),
      .drop_pulse (dp1)
`ifdef TS_QUEUE_STATS_EN
      ,
      .drop_cnt   (dc1),
      .hwm        (hw1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-cycle inputs and the expected pre-edge outputs of both instances.
   typedef struct {
      int wr; int id; int rd;
      int v0; int id0; int us0; int d0;
      int v1; int id1; int us1; int d1;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int w, input int id, input int r);
      wr_valid = (w != 0);
      wr_id    = ID_W'(id);
      wr_ts    = TS_W'(id) << 4;
      rd_ready = (r != 0);
   endtask

   task automatic check_dut(input int k, input string tag, input int v, input int id,
                            input int us, input int d);
      logic            av, af, ad;
      logic [ID_W-1:0] aid;
      logic [TS_W-1:0] ats, ets;
      logic [2:0]      au;
      av  = (k == 0) ? rv0  : rv1;
      aid = (k == 0) ? rid0 : rid1;
      ats = (k == 0) ? rts0 : rts1;
      au  = (k == 0) ? u0   : u1;
      af  = (k == 0) ? f0   : f1;
      ad  = (k == 0) ? dp0  : dp1;
      ets = TS_W'(id) << 4;
      chk($sformatf("%s dut%0d rd_valid", tag, k), 96'(av), 96'(v != 0));
      chk($sformatf("%s dut%0d usedw", tag, k), 96'(au), 96'(us));
      chk($sformatf("%s dut%0d full", tag, k), 96'(af), 96'(us == DEPTH));
      chk($sformatf("%s dut%0d drop_pulse", tag, k), 96'(ad), 96'(d != 0));
      if (v != 0) begin
         chk($sformatf("%s dut%0d rd_id", tag, k), 96'(aid), 96'(id));
         chk($sformatf("%s dut%0d rd_ts", tag, k), 96'(ats), 96'(ets));
      end
   endtask

   task automatic check_both(input string tag, input int v, input int id, input int us,
                             input int d);
      check_dut(0, tag, v, id, us, d);
      check_dut(1, tag, v, id, us, d);
   endtask

   initial begin
      // Ordering with a mid-stream write+pop, then fill past full, drain, and an ignored pop.
      tbl[0]  = '{1, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0};
      tbl[1]  = '{1, 2, 0,  1, 1, 1, 0,  1, 1, 1, 0};
      tbl[2]  = '{1, 3, 0,  1, 1, 2, 0,  1, 1, 2, 0};
      tbl[3]  = '{0, 0, 1,  1, 1, 3, 0,  1, 1, 3, 0};
      tbl[4]  = '{0, 0, 1,  1, 2, 2, 0,  1, 2, 2, 0};
      tbl[5]  = '{1, 4, 1,  1, 3, 1, 0,  1, 3, 1, 0};
      tbl[6]  = '{0, 0, 1,  1, 4, 1, 0,  1, 4, 1, 0};
      tbl[7]  = '{1, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0};
      tbl[8]  = '{1, 2, 0,  1, 1, 1, 0,  1, 1, 1, 0};
      tbl[9]  = '{1, 3, 0,  1, 1, 2, 0,  1, 1, 2, 0};
      tbl[10] = '{1, 4, 0,  1, 1, 3, 0,  1, 1, 3, 0};
      tbl[11] = '{1, 5, 0,  1, 1, 4, 1,  1, 1, 4, 1};
      tbl[12] = '{1, 6, 0,  1, 1, 4, 1,  1, 2, 4, 1};
      tbl[13] = '{0, 0, 1,  1, 1, 4, 0,  1, 3, 4, 0};
      tbl[14] = '{0, 0, 1,  1, 2, 3, 0,  1, 4, 3, 0};
      tbl[15] = '{0, 0, 1,  1, 3, 2, 0,  1, 5, 2, 0};
      tbl[16] = '{0, 0, 1,  1, 4, 1, 0,  1, 6, 1, 0};
      tbl[17] = '{0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0};
      tbl[18] = '{0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};

      aclr = 1'b1;
      drive(0, 0, 0);
      #1;
      check_both("reset", 0, 0, 0, 0);
      @(negedge clk);
      aclr = 1'b0;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         drive(tbl[i].wr, tbl[i].id, tbl[i].rd);
         #1;
         check_dut(0, $sformatf("vec%0d", i), tbl[i].v0, tbl[i].id0, tbl[i].us0, tbl[i].d0);
         check_dut(1, $sformatf("vec%0d", i), tbl[i].v1, tbl[i].id1, tbl[i].us1, tbl[i].d1);
      end

      // Full with simultaneous write and pop across pointer wrap.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1, 'h10 + i, 0);
         #1;
         check_both("fill", (i != 0) ? 1 : 0, 'h10, i, 0);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(1, 'h14 + i, 1);
         #1;
         check_both($sformatf("fullrw%0d", i), 1, 'h10 + i, 4, 0);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(0, 0, 1);
         #1;
         check_both($sformatf("drain%0d", i), 1, 'h1A + i, 4 - i, 0);
      end
      @(negedge clk);
      drive(0, 0, 0);
      #1;
      check_both("drained", 0, 0, 0, 0);

      // Asynchronous reset with three entries queued.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1, 'h31 + i, 0);
      end
      @(negedge clk);
      drive(0, 0, 0);
      #1;
      check_both("pre_aclr", 1, 'h31, 3, 0);
      #2;
      aclr = 1'b1;
      #1;
      check_both("aclr_async", 0, 0, 0, 0);
      @(negedge clk);
      aclr = 1'b0;
      drive(1, 'h55, 0);
      #1;
      check_both("no_bypass", 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0);
      #1;
      check_both("post_aclr", 1, 'h55, 1, 0);

`ifdef TS_QUEUE_STATS_EN
      aclr = 1'b1;
      #1;
      aclr = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         drive(1, i, 0);
      end
      @(negedge clk);
      drive(0, 0, 0);
      #1;
      chk("stats dut0 drop_cnt", 96'(dc0), 96'd1);
      chk("stats dut0 hwm", 96'(hw0), 96'd4);
      chk("stats dut1 drop_cnt", 96'(dc1), 96'd1);
      chk("stats dut1 hwm", 96'(hw1), 96'd4);
      aclr = 1'b1;
      #1;
      chk("stats dut0 drop_cnt cleared", 96'(dc0), 96'd0);
      chk("stats dut0 hwm cleared", 96'(hw0), 96'd0);
      chk("stats dut1 drop_cnt cleared", 96'(dc1), 96'd0);
      chk("stats dut1 hwm cleared", 96'(hw1), 96'd0);
      @(negedge clk);
      aclr = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
